prbs_gen_check: RTL

PRBS_GEN_CHECK -- requirements
Module: prbs_gen_check

---
 rtl/prbs_pkg.sv | 37 +++
 rtl/prbs_step.sv | 29 ++
 rtl/prbs_gen_check.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// PRBS generator/checker shared definitions:
// polynomial tables, mode and checker state encodings.
package prbs_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'b00,
        MODE_PRBS15 = 2'b01,
        MODE_PRBS23 = 2'b10,
        MODE_PRBS31 = 2'b11
    } prbs_mode_e;

    typedef enum logic {
        ST_SEED  = 1'b0,
        ST_CHECK = 1'b1
    } chk_state_e;

    // x^n + x^t + 1, indexed by mode
    localparam logic [4:0] LEN_TBL [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
    localparam logic [4:0] TAP_TBL [4] = '{5'd6, 5'd14, 5'd18, 5'd28};

    function automatic logic prbs_fb(input logic [30:0] s,
                                     input logic [1:0]  m);
        return s[LEN_TBL[m] - 5'd1] ^ s[TAP_TBL[m] - 5'd1];
    endfunction

    function automatic logic [30:0] len_mask(input logic [1:0] m);
        return 31'h7FFF_FFFF >> (5'd31 - LEN_TBL[m]);
    endfunction

    function automatic logic [5:0] seed_words(input logic [1:0]  m,
                                              input int unsigned w);
        int unsigned n;
        n = 32'(LEN_TBL[m]);
        return 6'((n + w - 1) / w);
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational W-step Fibonacci LFSR advance; oldest
// emitted bit lands in o_bits[W-1].
module prbs_step
    import prbs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [30:0]  i_state,
    input  logic [1:0]   i_mode,
    output logic [30:0]  o_state,
    output logic [W-1:0] o_bits
);

    logic [30:0] w_s;
    logic        w_fb;

    always_comb begin
        w_s    = i_state;
        w_fb   = 1'b0;
        o_bits = '0;
        for (int i = 0; i < W; i++) begin
            w_fb = prbs_fb(w_s, i_mode);
            w_s  = {w_s[29:0], w_fb};
            o_bits[W-1-i] = w_fb;
        end
        o_state = w_s;
    end

endmodule

// File: rtl/prbs_gen_check.sv
// PRBS7/15/23/31 word generator with error injection and a
// self-synchronising checker with loss-of-lock detection.
module prbs_gen_check
    import prbs_pkg::*;
#(
    parameter int W        = 8,
    parameter int CNT_W    = 16,
    parameter int LOSS_THR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             gen_en,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    input  logic             inj_err,
    output logic [W-1:0]     gen_data,
    output logic             gen_valid,
    input  logic [W-1:0]     chk_data,
    input  logic             chk_valid,
    output logic             locked,
    output logic             err_word,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    logic [30:0]      r_gen_st;
    logic [W-1:0]     r_gen_data;
    logic             r_gen_valid;
    logic             r_inj;
    logic [30:0]      w_gen_nxt;
    logic [W-1:0]     w_gen_bits;
    logic [W-1:0]     w_inj_mask;
    logic [30:0]      w_seed;

    chk_state_e       r_st, w_st;
    prbs_mode_e       r_mode_q;
    logic [30:0]      r_chk_st, w_chk_st;
    logic [5:0]       r_scnt, w_scnt;
    logic [7:0]       r_run, w_run;
    logic             r_err_word, w_err_word;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt;
    logic [30:0]      w_chk_unused;
    logic [W-1:0]     w_pred;
    logic [W-1:0]     w_diff;
    logic [5:0]       w_pop;
    logic [30:0]      w_load;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_sat;

    prbs_step #(.W(W)) u_gen_step (
        .i_state (r_gen_st),
        .i_mode  (mode),
        .o_state (w_gen_nxt),
        .o_bits  (w_gen_bits)
    );

    prbs_step #(.W(W)) u_chk_step (
        .i_state (r_chk_st),
        .i_mode  (mode),
        .o_state (w_chk_unused),
        .o_bits  (w_pred)
    );

    // an all-zero seed would lock the LFSR up
    assign w_seed = ((seed & len_mask(mode)) == 31'd0) ? '1 : seed;

    always_comb begin
        w_inj_mask    = '0;
        w_inj_mask[0] = inj_err | r_inj;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_st    <= '1;
            r_gen_data  <= '0;
            r_gen_valid <= 1'b0;
            r_inj       <= 1'b0;
        end else if (seed_load) begin
            r_gen_st    <= w_seed;
            r_gen_valid <= 1'b0;
            r_inj       <= r_inj | inj_err;
        end else if (gen_en) begin
            r_gen_st    <= w_gen_nxt;
            r_gen_data  <= w_gen_bits ^ w_inj_mask;
            r_gen_valid <= 1'b1;
            r_inj       <= 1'b0;
        end else begin
            r_gen_valid <= 1'b0;
            r_inj       <= r_inj | inj_err;
        end
    end

    // received bits always replace the state: self-synchronising
    if (W >= 31) begin : g_wide
        assign w_load = chk_data[30:0];
    end else begin : g_narrow
        assign w_load = {r_chk_st[30-W:0], chk_data};
    end

    assign w_diff = w_pred ^ chk_data;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + 6'(w_diff[i]);
        end
    end

    assign w_sum = {1'b0, r_err_cnt} + (CNT_W+1)'(w_pop);
    assign w_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_comb begin
        w_st       = r_st;
        w_chk_st   = r_chk_st;
        w_scnt     = r_scnt;
        w_run      = r_run;
        w_err_word = 1'b0;
        w_err_cnt  = r_err_cnt;
        if (mode != r_mode_q) begin
            w_st   = ST_SEED;
            w_scnt = '0;
            w_run  = '0;
        end else if (chk_valid) begin
            w_chk_st = w_load;
            unique case (r_st)
                ST_SEED: begin
                    if (r_scnt == seed_words(mode, W) - 6'd1) begin
                        w_st   = ST_CHECK;
                        w_scnt = '0;
                    end else begin
                        w_scnt = r_scnt + 6'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_pop != 6'd0) begin
                        w_err_word = 1'b1;
                        w_err_cnt  = w_sat;
                        if (r_run == 8'(LOSS_THR - 1)) begin
                            w_st  = ST_SEED;
                            w_run = '0;
                        end else begin
                            w_run = r_run + 8'd1;
                        end
                    end else begin
                        w_run = '0;
                    end
                end
                default: w_st = ST_SEED;
            endcase
        end
        if (clr_cnt) begin
            w_err_cnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= ST_SEED;
            r_mode_q   <= MODE_PRBS7;
            r_chk_st   <= '1;
            r_scnt     <= '0;
            r_run      <= '0;
            r_err_word <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_st       <= w_st;
            r_mode_q   <= prbs_mode_e'(mode);
            r_chk_st   <= w_chk_st;
            r_scnt     <= w_scnt;
            r_run      <= w_run;
            r_err_word <= w_err_word;
            r_err_cnt  <= w_err_cnt;
        end
    end

    assign gen_data  = r_gen_data;
    assign gen_valid = r_gen_valid;
    assign locked    = (r_st == ST_CHECK);
    assign err_word  = r_err_word;
    assign err_cnt   = r_err_cnt;

endmodule
